// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and small helpers used across the fetch slice.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and clear; head is read combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               din_i,
  output logic [WIDTH-1:0]               dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Credit-limited instruction fetch: issues PC reads, tags them in order, and
// buffers returned instructions for decode, with flush-time response dropping.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned WORDSIZE   = XLEN,
  parameter int unsigned INST_WIDTH = ILEN,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORDSIZE-1:0]   pc_addr,
  input  logic                  pc_valid,
  output logic                  pc_ready,
  output logic                  mem_req_valid,
  output logic [WORDSIZE-1:0]   mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [INST_WIDTH-1:0] mem_rsp_data,
  input  logic                  flush,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [WORDSIZE-1:0]   inst_pc,
  output logic                  inst_misaligned,
  input  logic                  inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 2;
  localparam int unsigned QW = WORDSIZE + INST_WIDTH;

  logic [CW-1:0]       drop_q, drop_d;
  logic [CW-1:0]       outstanding, queued;
  logic [SW-1:0]       inflight;
  logic                credit;
  logic                pc_hs, rsp_take, rsp_any, inst_pop;
  logic                tag_full, tag_empty, q_full, q_empty;
  logic [WORDSIZE-1:0] tag_head;
  logic [QW-1:0]       q_head;

  // Outstanding requests are exactly the tags waiting in the tag FIFO.
  assign inflight = SW'(outstanding) + SW'(queued) + SW'(drop_q);
  assign credit   = inflight < SW'(DEPTH);

  assign mem_req_valid = !reset && pc_valid && credit && !flush && !tag_full;
  assign mem_req_addr  = pc_addr;
  assign pc_hs         = mem_req_valid && mem_req_ready;
  assign pc_ready      = pc_hs;

  assign rsp_any  = mem_rsp_valid && ((drop_q != '0) || !tag_empty);
  assign rsp_take = mem_rsp_valid && !flush && (drop_q == '0) && !tag_empty && !q_full;

  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      // A response in the flush cycle retires one pending item (dropped or live).
      drop_d = drop_q + outstanding - CW'(rsp_any);
    end else if (mem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  sync_fifo #(
    .WIDTH (WORDSIZE),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (pc_hs),
    .pop_i   (rsp_take),
    .din_i   (pc_addr),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outstanding)
  );

  sync_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (rsp_take),
    .pop_i   (inst_pop),
    .din_i   ({tag_head, mem_rsp_data}),
    .dout_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (queued)
  );

  assign inst_valid      = !reset && !q_empty;
  assign inst_pop        = inst_valid && inst_ready;
  assign inst_data       = inst_valid ? q_head[INST_WIDTH-1:0] : '0;
  assign inst_pc         = inst_valid ? q_head[QW-1:INST_WIDTH] : '0;
  assign inst_misaligned = inst_valid && is_misaligned(q_head[INST_WIDTH+1:INST_WIDTH]);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle bench for instruction_fetch with DEPTH=2.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_misaligned;
  logic        inst_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .WORDSIZE   (64),
    .INST_WIDTH (32),
    .DEPTH      (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_addr         (pc_addr),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .flush           (flush),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_misaligned (inst_misaligned),
    .inst_ready      (inst_ready)
  );

  task automatic drive(input logic pv, input logic [63:0] pa, input logic rv,
                       input logic [31:0] rd, input logic fl, input logic ir);
    pc_valid      = pv;
    pc_addr       = pa;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    flush         = fl;
    inst_ready    = ir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_req_ready = 1'b1;
    drive(1'b1, 64'h40, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    tick();
    tick();
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    tests_run++; if (inst_data !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
    tests_run++; if (inst_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    tests_run++; if (inst_misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned: got %b want 0", inst_misaligned); end
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_in_order();
    drive(1'b1, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL order_req_valid: got %b want 1", mem_req_valid); end
    tests_run++; if (mem_req_addr !== 64'h0) begin tests_failed++; $display("FAIL order_req_addr: got %h want 0", mem_req_addr); end
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL order_rdy0: got %b want 1", pc_ready); end
    tick();
    drive(1'b1, 64'h20, 1'b1, 32'h1111_0000, 1'b0, 1'b1);
    tests_run++; if (mem_req_addr !== 64'h20) begin tests_failed++; $display("FAIL order_req_addr20: got %h want 20", mem_req_addr); end
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL order_rdy20: got %b want 1", pc_ready); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL order_early_valid: got %b want 0", inst_valid); end
    tick();
    drive(1'b1, 64'h40, 1'b1, 32'h2222_0020, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL order_valid0: got %b want 1", inst_valid); end
    tests_run++; if (inst_pc !== 64'h0) begin tests_failed++; $display("FAIL order_pc0: got %h want 0", inst_pc); end
    tests_run++; if (inst_data !== 32'h1111_0000) begin tests_failed++; $display("FAIL order_data0: got %h want 11110000", inst_data); end
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL order_no_credit: got %b want 0", pc_ready); end
    tick();
    drive(1'b1, 64'h40, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h20) begin tests_failed++; $display("FAIL order_pc20: got %h want 20", inst_pc); end
    tests_run++; if (inst_data !== 32'h2222_0020) begin tests_failed++; $display("FAIL order_data20: got %h want 22220020", inst_data); end
    tests_run++; if (inst_misaligned !== 1'b0) begin tests_failed++; $display("FAIL order_mis20: got %b want 0", inst_misaligned); end
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL order_rdy40: got %b want 1", pc_ready); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h3333_0040, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL order_gap_valid: got %b want 0", inst_valid); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h40) begin tests_failed++; $display("FAIL order_pc40: got %h want 40", inst_pc); end
    tests_run++; if (inst_data !== 32'h3333_0040) begin tests_failed++; $display("FAIL order_data40: got %h want 33330040", inst_data); end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 64'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_rdy200: got %b want 1", pc_ready); end
    tick();
    drive(1'b1, 64'h204, 1'b1, 32'hA000_0200, 1'b0, 1'b0);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_rdy204: got %b want 1", pc_ready); end
    tick();
    drive(1'b1, 64'h208, 1'b1, 32'hA000_0204, 1'b0, 1'b0);
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_third_rejected: got %b want 0", pc_ready); end
    tick();
    drive(1'b1, 64'h208, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_rejected: got %b want 0", pc_ready); end
    tests_run++; if (inst_pc !== 64'h200) begin tests_failed++; $display("FAIL bp_hold_pc: got %h want 200", inst_pc); end
    tick();
    drive(1'b1, 64'h208, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_no_bypass: got %b want 0", pc_ready); end
    tests_run++; if (inst_data !== 32'hA000_0200) begin tests_failed++; $display("FAIL bp_hold_data: got %h want a0000200", inst_data); end
    tick();
    drive(1'b1, 64'h208, 1'b0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_third_accepted: got %b want 1", pc_ready); end
    tests_run++; if (inst_pc !== 64'h204) begin tests_failed++; $display("FAIL bp_pc204: got %h want 204", inst_pc); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hA000_0208, 1'b0, 1'b1);
    tests_run++; if (inst_data !== 32'hA000_0204) begin tests_failed++; $display("FAIL bp_data204: got %h want a0000204", inst_data); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h208) begin tests_failed++; $display("FAIL bp_pc208: got %h want 208", inst_pc); end
    tests_run++; if (inst_data !== 32'hA000_0208) begin tests_failed++; $display("FAIL bp_data208: got %h want a0000208", inst_data); end
    tick();
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %b want 0", inst_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 64'h300, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 64'h304, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL fl_rdy304: got %b want 1", pc_ready); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 64'h100, 1'b1, 32'hBAD0_0300, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL fl_drop_credit: got %b want 0", pc_ready); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_valid_a: got %b want 0", inst_valid); end
    tick();
    drive(1'b1, 64'h100, 1'b1, 32'hBAD0_0304, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL fl_rdy100: got %b want 1", pc_ready); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_valid_b: got %b want 0", inst_valid); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'h5555_0100, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_valid_c: got %b want 0", inst_valid); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h100) begin tests_failed++; $display("FAIL fl_pc100: got %h want 100", inst_pc); end
    tests_run++; if (inst_data !== 32'h5555_0100) begin tests_failed++; $display("FAIL fl_data100: got %h want 55550100", inst_data); end
    tick();
  endtask

  task automatic test_flush_full();
    drive(1'b1, 64'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h404, 1'b1, 32'hA400_0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hA404_0000, 1'b1, 1'b0);
    tests_run++; if (inst_pc !== 64'h400) begin tests_failed++; $display("FAIL ff_pre_pc: got %h want 400", inst_pc); end
    tick();
    drive(1'b1, 64'h500, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL ff_nothing_a: got %b want 0", inst_valid); end
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL ff_rdy500: got %b want 1", pc_ready); end
    tick();
    drive(1'b1, 64'h504, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL ff_nothing_b: got %b want 0", inst_valid); end
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL ff_rdy504: got %b want 1", pc_ready); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hB500_0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hB504_0000, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h500) begin tests_failed++; $display("FAIL ff_pc500: got %h want 500", inst_pc); end
    tests_run++; if (inst_data !== 32'hB500_0000) begin tests_failed++; $display("FAIL ff_data500: got %h want b5000000", inst_data); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h504) begin tests_failed++; $display("FAIL ff_pc504: got %h want 504", inst_pc); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL ff_stray_rsp: got %b want 0", inst_valid); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 64'h22, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL mis_rdy: got %b want 1", pc_ready); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hC022_0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_pc !== 64'h22) begin tests_failed++; $display("FAIL mis_pc: got %h want 22", inst_pc); end
    tests_run++; if (inst_misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_flag: got %b want 1", inst_misaligned); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'h700, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 64'h704, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b1, 64'h708, 1'b1, 32'hD700_0000, 1'b0, 1'b1);
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_req_in_reset: got %b want 0", mem_req_valid); end
    tick();
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid: got %b want 0", inst_valid); end
    tests_run++; if (inst_data !== 32'h0) begin tests_failed++; $display("FAIL rm_data: got %h want 0", inst_data); end
    tests_run++; if (inst_pc !== 64'h0) begin tests_failed++; $display("FAIL rm_pc: got %h want 0", inst_pc); end
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_req_idle: got %b want 0", mem_req_valid); end
    drive(1'b1, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_counts_cleared: got %b want 1", pc_ready); end
    tick();
    drive(1'b0, 64'h0, 1'b1, 32'hE000_0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_fresh_valid: got %b want 1", inst_valid); end
    tests_run++; if (inst_data !== 32'hE000_0000) begin tests_failed++; $display("FAIL rm_fresh_data: got %h want e0000000", inst_data); end
    tests_run++; if (inst_pc !== 64'h0) begin tests_failed++; $display("FAIL rm_fresh_pc: got %h want 0", inst_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_flush();
    test_flush_full();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
